// File: rtl/vec_cache_entry_recycle.sv
// Per-entry FREE->RSVD->BUSY->DRAIN->FREE tracker feeding the pre-allocator's free vector.
// Latency: 1 cycle per transition, RELEASE_LAT+1 cycles from release to FREE; rel_rdy is always 1.
// Optional checking (err_vld/err_index pulses and SVA) is enabled by VEC_CACHE_ENTRY_CHECK_EN.
module vec_cache_entry_recycle #(
  parameter int ENTRY_NUM      = 32,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int RELEASE_LAT    = 2,
  parameter int CNT_WIDTH      = $clog2(ENTRY_NUM + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ENTRY_NUM-1:0]      v_free_vld,
  input  logic [ENTRY_NUM-1:0]      v_free_rdy,
  input  logic                      alloc_vld,
  input  logic [ENTRY_ID_WIDTH-1:0] alloc_index,
  input  logic                      rel_vld,
  output logic                      rel_rdy,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_index,
  output logic [CNT_WIDTH-1:0]      free_cnt,
  output logic [CNT_WIDTH-1:0]      busy_cnt,
  output logic                      err_vld,
  output logic [ENTRY_ID_WIDTH-1:0] err_index
);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_RSVD  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } entry_state_t;

  localparam int DW = (RELEASE_LAT > 1) ? $clog2(RELEASE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = (RELEASE_LAT > 0) ? DW'(RELEASE_LAT - 1) : '0;

  entry_state_t         state      [ENTRY_NUM];
  entry_state_t         state_nxt  [ENTRY_NUM];
  logic [DW-1:0]        drain_cnt  [ENTRY_NUM];
  logic [DW-1:0]        drain_nxt  [ENTRY_NUM];
  logic                 rel_fire;
  logic                 alloc_ok;
  logic                 rel_ok;
  logic [CNT_WIDTH-1:0] free_nxt;
  logic [CNT_WIDTH-1:0] busy_nxt;

  // Back-pressure hook for a future release queue; today every release is taken.
  assign rel_rdy  = 1'b1;
  assign rel_fire = rel_vld && rel_rdy;

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      v_free_vld[i] = (state[i] == ST_FREE);
    end
  end

  // Out-of-range indices never match an entry, so they fall out as illegal.
  always_comb begin
    alloc_ok = 1'b0;
    rel_ok   = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (alloc_vld && (alloc_index == ENTRY_ID_WIDTH'(i)) && (state[i] == ST_RSVD)) begin
        alloc_ok = 1'b1;
      end
      if (rel_fire && (rel_index == ENTRY_ID_WIDTH'(i)) && (state[i] == ST_BUSY)) begin
        rel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    free_nxt = '0;
    busy_nxt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      state_nxt[i] = state[i];
      drain_nxt[i] = drain_cnt[i];
      case (state[i])
        ST_FREE: begin
          if (v_free_rdy[i]) begin
            state_nxt[i] = ST_RSVD;
          end
        end
        ST_RSVD: begin
          if (alloc_ok && (alloc_index == ENTRY_ID_WIDTH'(i))) begin
            state_nxt[i] = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (rel_ok && (rel_index == ENTRY_ID_WIDTH'(i))) begin
            if (RELEASE_LAT > 0) begin
              state_nxt[i] = ST_DRAIN;
              drain_nxt[i] = DRAIN_INIT;
            end else begin
              state_nxt[i] = ST_FREE;
            end
          end
        end
        default: begin
          if (drain_cnt[i] == '0) begin
            state_nxt[i] = ST_FREE;
          end else begin
            drain_nxt[i] = drain_cnt[i] - DW'(1);
          end
        end
      endcase
      // Counting the next state keeps the counters exact under multi-hot grants.
      free_nxt = free_nxt + CNT_WIDTH'(state_nxt[i] == ST_FREE);
      busy_nxt = busy_nxt + CNT_WIDTH'(state_nxt[i] == ST_BUSY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state[i]     <= ST_FREE;
        drain_cnt[i] <= '0;
      end
      free_cnt <= CNT_WIDTH'(ENTRY_NUM);
      busy_cnt <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state[i]     <= state_nxt[i];
        drain_cnt[i] <= drain_nxt[i];
      end
      free_cnt <= free_nxt;
      busy_cnt <= busy_nxt;
    end
  end

`ifdef VEC_CACHE_ENTRY_CHECK_EN
  logic alloc_err;
  logic rel_err;

  assign alloc_err = alloc_vld && !alloc_ok;
  assign rel_err   = rel_fire && !rel_ok;

  // Alloc errors take precedence when both paths misbehave in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vld   <= 1'b0;
      err_index <= '0;
    end else begin
      err_vld <= alloc_err || rel_err;
      if (alloc_err) begin
        err_index <= alloc_index;
      end else if (rel_err) begin
        err_index <= rel_index;
      end
    end
  end

  int n_free;
  int n_rsvd;
  int n_busy;
  int n_drain;

  always_comb begin
    n_free  = 0;
    n_rsvd  = 0;
    n_busy  = 0;
    n_drain = 0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      case (state[i])
        ST_FREE: n_free  = n_free + 1;
        ST_RSVD: n_rsvd  = n_rsvd + 1;
        ST_BUSY: n_busy  = n_busy + 1;
        default: n_drain = n_drain + 1;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(v_free_rdy));

  a_cnt_invariant: assert property (@(posedge clk) disable iff (rst)
    (int'(free_cnt) == n_free) && (int'(busy_cnt) == n_busy) &&
    (n_free + n_rsvd + n_busy + n_drain == ENTRY_NUM));
`else
  assign err_vld   = 1'b0;
  assign err_index = '0;
`endif

endmodule

// File: tb/tb_vec_cache_entry_recycle.sv
// Directed bench for vec_cache_entry_recycle: reserve/alloc/release/drain lifecycle, collisions, errors, reset.
module tb_vec_cache_entry_recycle;

`ifdef VEC_CACHE_ENTRY_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] v_free_vld;
  logic [31:0] v_free_rdy = '0;
  logic        alloc_vld = 1'b0;
  logic [4:0]  alloc_index = '0;
  logic        rel_vld = 1'b0;
  logic        rel_rdy;
  logic [4:0]  rel_index = '0;
  logic [5:0]  free_cnt;
  logic [5:0]  busy_cnt;
  logic        err_vld;
  logic [4:0]  err_index;

  int checks = 0;
  int failures = 0;

  vec_cache_entry_recycle #(
    .ENTRY_NUM(32), .ENTRY_ID_WIDTH(5), .RELEASE_LAT(2), .CNT_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst),
    .v_free_vld(v_free_vld), .v_free_rdy(v_free_rdy),
    .alloc_vld(alloc_vld), .alloc_index(alloc_index),
    .rel_vld(rel_vld), .rel_rdy(rel_rdy), .rel_index(rel_index),
    .free_cnt(free_cnt), .busy_cnt(busy_cnt),
    .err_vld(err_vld), .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_free_rdy = '0;
    alloc_vld  = 1'b0;
    rel_vld    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (v_free_vld !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_free_vec got=%h exp=ffffffff", v_free_vld); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL reset_free_cnt got=%0d exp=32", free_cnt); end
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
    checks++; if (rel_rdy !== 1'b1) begin failures++; $display("FAIL reset_rel_rdy got=%b exp=1", rel_rdy); end
    checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL reset_err_vld got=%b exp=0", err_vld); end
    checks++; if (err_index !== 5'd0) begin failures++; $display("FAIL reset_err_index got=%0d exp=0", err_index); end
  endtask

  task automatic test_alloc();
    v_free_rdy = 32'd1 << 5;
    cyc();
    idle();
    checks++; if (v_free_vld[5] !== 1'b0) begin failures++; $display("FAIL rsv_vec5 got=%b exp=0", v_free_vld[5]); end
    checks++; if (free_cnt !== 6'd31) begin failures++; $display("FAIL rsv_free_cnt got=%0d exp=31", free_cnt); end
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL rsv_busy_cnt got=%0d exp=0", busy_cnt); end
    alloc_vld = 1'b1; alloc_index = 5'd5;
    cyc();
    idle();
    checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL alloc_busy_cnt got=%0d exp=1", busy_cnt); end
    checks++; if (free_cnt !== 6'd31) begin failures++; $display("FAIL alloc_free_cnt got=%0d exp=31", free_cnt); end
  endtask

  task automatic test_release_drain();
    rel_vld = 1'b1; rel_index = 5'd5;
    cyc();
    idle();
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL drain_t1_busy got=%0d exp=0", busy_cnt); end
    checks++; if (v_free_vld[5] !== 1'b0) begin failures++; $display("FAIL drain_t1_vec5 got=%b exp=0", v_free_vld[5]); end
    checks++; if (free_cnt !== 6'd31) begin failures++; $display("FAIL drain_t1_free got=%0d exp=31", free_cnt); end
    cyc();
    checks++; if (v_free_vld[5] !== 1'b0) begin failures++; $display("FAIL drain_t2_vec5 got=%b exp=0", v_free_vld[5]); end
    cyc();
    checks++; if (v_free_vld[5] !== 1'b1) begin failures++; $display("FAIL drain_t3_vec5 got=%b exp=1", v_free_vld[5]); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL drain_t3_free got=%0d exp=32", free_cnt); end
  endtask

  task automatic test_simultaneous();
    v_free_rdy = 32'd1 << 2;
    cyc();
    idle();
    v_free_rdy = 32'd1 << 1; alloc_vld = 1'b1; alloc_index = 5'd2;
    cyc();
    idle();
    checks++; if (free_cnt !== 6'd30 || busy_cnt !== 6'd1) begin failures++; $display("FAIL sim_setup_cnt got=%0d/%0d exp=30/1", free_cnt, busy_cnt); end
    v_free_rdy = 32'd1; alloc_vld = 1'b1; alloc_index = 5'd1; rel_vld = 1'b1; rel_index = 5'd2;
    cyc();
    idle();
    checks++; if (v_free_vld[2:0] !== 3'b000) begin failures++; $display("FAIL sim_vec got=%b exp=000", v_free_vld[2:0]); end
    checks++; if (free_cnt !== 6'd29) begin failures++; $display("FAIL sim_free_cnt got=%0d exp=29", free_cnt); end
    checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sim_busy_cnt got=%0d exp=1", busy_cnt); end
    cyc();
    cyc();
    checks++; if (v_free_vld[2:0] !== 3'b100) begin failures++; $display("FAIL sim_drained_vec got=%b exp=100", v_free_vld[2:0]); end
    checks++; if (free_cnt !== 6'd30) begin failures++; $display("FAIL sim_drained_free got=%0d exp=30", free_cnt); end
    alloc_vld = 1'b1; alloc_index = 5'd0;
    cyc();
    idle();
    checks++; if (busy_cnt !== 6'd2) begin failures++; $display("FAIL sim_alloc0_busy got=%0d exp=2", busy_cnt); end
    rel_vld = 1'b1; rel_index = 5'd0;
    cyc();
    rel_index = 5'd1;
    cyc();
    idle();
    cyc();
    cyc();
    checks++; if (free_cnt !== 6'd32 || busy_cnt !== 6'd0) begin failures++; $display("FAIL sim_cleanup_cnt got=%0d/%0d exp=32/0", free_cnt, busy_cnt); end
  endtask

  task automatic test_illegal();
    rel_vld = 1'b1; rel_index = 5'd7;
    cyc();
    idle();
    checks++; if (v_free_vld[7] !== 1'b1) begin failures++; $display("FAIL ill_rel_vec7 got=%b exp=1", v_free_vld[7]); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL ill_rel_free got=%0d exp=32", free_cnt); end
    checks++; if (err_vld !== ERR_EN) begin failures++; $display("FAIL ill_rel_err_vld got=%b exp=%b", err_vld, ERR_EN); end
    checks++; if (err_index !== (ERR_EN ? 5'd7 : 5'd0)) begin failures++; $display("FAIL ill_rel_err_index got=%0d exp=%0d", err_index, ERR_EN ? 7 : 0); end
    cyc();
    checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got=%b exp=0", err_vld); end
    alloc_vld = 1'b1; alloc_index = 5'd9;
    cyc();
    idle();
    checks++; if (v_free_vld[9] !== 1'b1 || busy_cnt !== 6'd0) begin failures++; $display("FAIL ill_alloc_state got=%b/%0d exp=1/0", v_free_vld[9], busy_cnt); end
    checks++; if (err_vld !== ERR_EN || err_index !== (ERR_EN ? 5'd9 : 5'd0)) begin failures++; $display("FAIL ill_alloc_err got=%b/%0d exp=%b/%0d", err_vld, err_index, ERR_EN, ERR_EN ? 9 : 0); end
    alloc_vld = 1'b1; alloc_index = 5'd3; rel_vld = 1'b1; rel_index = 5'd4;
    cyc();
    idle();
    checks++; if (err_vld !== ERR_EN || err_index !== (ERR_EN ? 5'd3 : 5'd0)) begin failures++; $display("FAIL ill_prio_err got=%b/%0d exp=%b/%0d", err_vld, err_index, ERR_EN, ERR_EN ? 3 : 0); end
    checks++; if (free_cnt !== 6'd32) begin failures++; $display("FAIL ill_prio_free got=%0d exp=32", free_cnt); end
    v_free_rdy = 32'd1 << 6;
    cyc();
    idle();
    alloc_vld = 1'b1; alloc_index = 5'd6; rel_vld = 1'b1; rel_index = 5'd6;
    cyc();
    idle();
    checks++; if (busy_cnt !== 6'd1 || v_free_vld[6] !== 1'b0) begin failures++; $display("FAIL same_idx_state got=%0d/%b exp=1/0", busy_cnt, v_free_vld[6]); end
    checks++; if (err_vld !== ERR_EN || err_index !== (ERR_EN ? 5'd6 : 5'd0)) begin failures++; $display("FAIL same_idx_err got=%b/%0d exp=%b/%0d", err_vld, err_index, ERR_EN, ERR_EN ? 6 : 0); end
    rel_vld = 1'b1; rel_index = 5'd6;
    cyc();
    idle();
    cyc();
    cyc();
    checks++; if (v_free_vld[6] !== 1'b1 || free_cnt !== 6'd32) begin failures++; $display("FAIL same_idx_drain got=%b/%0d exp=1/32", v_free_vld[6], free_cnt); end
  endtask

  task automatic test_fill_reset();
    for (int i = 0; i < 32; i++) begin
      v_free_rdy  = 32'd1 << i;
      alloc_vld   = (i > 0);
      alloc_index = 5'(i - 1);
      cyc();
    end
    v_free_rdy = '0; alloc_vld = 1'b1; alloc_index = 5'd31;
    cyc();
    idle();
    checks++; if (v_free_vld !== 32'h0) begin failures++; $display("FAIL fill_vec got=%h exp=00000000", v_free_vld); end
    checks++; if (free_cnt !== 6'd0) begin failures++; $display("FAIL fill_free got=%0d exp=0", free_cnt); end
    checks++; if (busy_cnt !== 6'd32) begin failures++; $display("FAIL fill_busy got=%0d exp=32", busy_cnt); end
    for (int i = 0; i < 4; i++) begin
      rel_vld = 1'b1; rel_index = 5'(i);
      cyc();
    end
    idle();
    checks++; if (v_free_vld !== 32'h3 || free_cnt !== 6'd2 || busy_cnt !== 6'd28) begin failures++; $display("FAIL middrain got=%h/%0d/%0d exp=3/2/28", v_free_vld, free_cnt, busy_cnt); end
    rst = 1'b1;
    #2;
    checks++; if (v_free_vld !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_async_vec got=%h exp=ffffffff", v_free_vld); end
    checks++; if (free_cnt !== 6'd32 || busy_cnt !== 6'd0) begin failures++; $display("FAIL rst_async_cnt got=%0d/%0d exp=32/0", free_cnt, busy_cnt); end
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    checks++; if (v_free_vld !== 32'hFFFF_FFFF || free_cnt !== 6'd32) begin failures++; $display("FAIL rst_after_vec got=%h/%0d exp=ffffffff/32", v_free_vld, free_cnt); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_reset();
    test_alloc();
    test_release_drain();
    test_simultaneous();
    test_illegal();
    test_fill_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
